// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic layer (adder, comparator, divider).
package arith_pkg;

    localparam int W     = 32;
    localparam int CNT_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } div_state_t;

endpackage

// File: rtl/div_32_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module div_32_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] r_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] r_o,
    output logic [W-1:0] q_o
);

    logic [W:0] t;
    logic       qbit;

    // The partial remainder is always below the divisor, so the result of
    // the subtraction fits back into W bits and the wrap of the low bits
    // gives the exact difference.
    always_comb begin
        t    = {r_i, q_i[W-1]};
        qbit = (t >= {1'b0, d_i});
        r_o  = qbit ? (t[W-1:0] - d_i) : t[W-1:0];
        q_o  = {q_i[W-2:0], qbit};
    end

endmodule

// File: rtl/div_32.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_32_DZ_FLAG_EN adds a dz port and a one-cycle divide-by-zero path.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring step per clock, 32 steps
// DONE  | done pulse cycle; start accepted here as in IDLE
module div_32 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
`ifdef DIV_32_DZ_FLAG_EN
    output logic         dz,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    import arith_pkg::*;

    div_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   d_q, d_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   quot_q, quot_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   r_nxt, q_nxt;
`ifdef DIV_32_DZ_FLAG_EN
    logic           dz_q, dz_d;
`endif

    div_32_step #(.W(W)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (r_nxt),
        .q_o (q_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV_32_DZ_FLAG_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef DIV_32_DZ_FLAG_EN
                    dz_d    = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d   = r_nxt;
                q_d   = q_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W - 1)) begin
                    quot_d  = q_nxt;
                    rem_d   = r_nxt;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
`ifdef DIV_32_DZ_FLAG_EN
                // q_q still holds the untouched dividend on the first step.
                if (d_q == '0) begin
                    quot_d  = '1;
                    rem_d   = q_q;
                    dz_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef DIV_32_DZ_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef DIV_32_DZ_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
`ifdef DIV_32_DZ_FLAG_EN
    assign dz        = dz_q;
`endif

endmodule

// File: tb/tb_div_32.sv
// Bench for div_32: cycle-level arithmetic model plus directed literal checks.
module tb_div_32;

    localparam bit DZ_EN =
`ifdef DIV_32_DZ_FLAG_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend, divisor;
    logic        busy, done;
    logic [31:0] quotient, remainder;
`ifdef DIV_32_DZ_FLAG_EN
    logic        dz;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef DIV_32_DZ_FLAG_EN
        .dz        (dz),
`endif
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: results are plain / and %, latency is a remaining-cycle count.
    bit          m_busy, m_done, m_dz, p_dz;
    logic [31:0] m_q, m_r, p_q, p_r;
    int          left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_dz = 0; p_dz = 0;
            m_q = 0; m_r = 0; p_q = 0; p_r = 0; left = 0;
        end else if (m_busy) begin
            left--;
            if (left == 0) begin
                m_busy = 0; m_done = 1;
                m_q = p_q; m_r = p_r; m_dz = p_dz;
            end
        end else begin
            m_done = 0;
            if (start === 1'b1) begin
                m_busy = 1;
                m_dz   = 0;
                if (divisor == 0) begin
                    p_q = 32'hFFFF_FFFF; p_r = dividend; p_dz = 1;
                end else begin
                    p_q = dividend / divisor; p_r = dividend % divisor; p_dz = 0;
                end
                left = (DZ_EN && divisor == 0) ? 1 : 32;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("quotient", quotient, m_q);
        chk("remainder", remainder, m_r);
`ifdef DIV_32_DZ_FLAG_EN
        chk("dz", dz, m_dz);
`endif
    end

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; leaves the bench at the negedge after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
    endtask

    task automatic wait_done(input string nm, input logic [31:0] eq, input logic [31:0] er,
                             input int lat);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(lat));
        chk({nm, " q"}, quotient, eq);
        chk({nm, " r"}, remainder, er);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset q", quotient, 0);
        chk("reset r", remainder, 0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(100, 7);
        wait_done("100/7", 14, 2, 32);
        start_op(32'hFFFF_FFFF, 1);
        wait_done("max/1", 32'hFFFF_FFFF, 0, 32);
        start_op(32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("max/msb", 1, 32'h7FFF_FFFF, 32);
        start_op(5, 9);
        wait_done("5/9", 0, 5, 32);
        start_op(9, 5);
        wait_done("9/5 back-to-back", 1, 4, 32);
        start_op(1234, 0);
        wait_done("1234/0", 32'hFFFF_FFFF, 1234, DZ_EN ? 1 : 32);
`ifdef DIV_32_DZ_FLAG_EN
        chk("1234/0 dz", dz, 1);
`endif

        start_op(1000, 10);
        repeat (8) @(negedge clk);
        start = 1'b1; dividend = 7; divisor = 3;
        @(negedge clk);
        start = 1'b0; dividend = 55; divisor = 2;
        wait_done("1000/10 ignore start", 100, 0, 23);
`ifdef DIV_32_DZ_FLAG_EN
        chk("dz cleared", dz, 0);
`endif

        @(negedge clk);
        start_op(1000, 10);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort q", quotient, 0);
        chk("abort r", remainder, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("no done after abort", 32'(seen), 0);

        repeat (3000) begin
            @(negedge clk);
            start    = ($urandom_range(0, 5) == 0);
            dividend = rnd();
            divisor  = rnd();
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
